// File: rtl/game_sequencer.sv
// Space Invaders game controller: single-clock game_tick enable, IDLE/PLAY/WIN/LOSE
// sequencing, fire-request arbitration and one-cycle sound-effect triggers.
module game_sequencer #(
    parameter int unsigned TICK_DIV       = 4194304,
    parameter int unsigned END_HOLD_TICKS = 128,
    parameter int unsigned CNT_W          = 22
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       fire_btn,
    input  logic       aliens_defeated,
    input  logic       reached_bottom,
    input  logic       bullet_onscreen,
    output logic       game_tick,
    output logic       world_reset,
    output logic       fire_req,
    output logic       sfx_shot,
    output logic       sfx_end,
    output logic [1:0] state
);

    localparam int unsigned HOLD_W = $clog2(END_HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(END_HOLD_TICKS);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WIN  = 2'b10,
        S_LOSE = 2'b11
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic start_s1, start_s2, start_q;
    logic fire_s1, fire_s2, fire_q;
    logic start_rise, fire_rise;

    logic [CNT_W-1:0]  tick_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              tc;
    logic              state_change;
    logic              stay_play;
    logic              tick_d;
    logic              fire_pending;
    logic              pending_d;

    assign state    = cur_state;
    assign fire_req = fire_pending;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge board_clk) begin
        if (reset) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_q  <= 1'b0;
            fire_s1  <= 1'b0;
            fire_s2  <= 1'b0;
            fire_q   <= 1'b0;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            start_q  <= start_s2;
            fire_s1  <= fire_btn;
            fire_s2  <= fire_s1;
            fire_q   <= fire_s2;
        end
    end

    assign start_rise = start_s2 & ~start_q;
    assign fire_rise  = fire_s2 & ~fire_q;

    assign tc = (cur_state != S_IDLE) && (tick_cnt == CNT_MAX);

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (start_rise) nxt_state = S_PLAY;
            end
            S_PLAY: begin
                if (!start_s2)            nxt_state = S_IDLE;
                else if (reached_bottom)  nxt_state = S_LOSE;
                else if (aliens_defeated) nxt_state = S_WIN;
            end
            S_WIN, S_LOSE: begin
                if ((hold_cnt == HOLD_MAX) && !start_s2) nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    assign state_change = (nxt_state != cur_state);
    assign stay_play    = (cur_state == S_PLAY) && (nxt_state == S_PLAY);
    // A tick on the cycle PLAY is left would leak into WIN/LOSE, so it is suppressed
    assign tick_d       = tc && stay_play;

    always_comb begin
        pending_d = fire_pending;
        if (!stay_play)
            pending_d = 1'b0;
        else if (fire_pending && game_tick)
            pending_d = 1'b0;
        else if (!fire_pending && fire_rise && !bullet_onscreen)
            pending_d = 1'b1;
    end

    always_ff @(posedge board_clk) begin
        if (reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_ff @(posedge board_clk) begin
        if (reset || state_change || (cur_state == S_IDLE) || tc)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge board_clk) begin
        if (reset || state_change)
            hold_cnt <= '0;
        else if (tc && (hold_cnt != HOLD_MAX))
            hold_cnt <= hold_cnt + 1'b1;
    end

    always_ff @(posedge board_clk) begin
        if (reset) begin
            game_tick    <= 1'b0;
            world_reset  <= 1'b1;
            fire_pending <= 1'b0;
            sfx_shot     <= 1'b0;
            sfx_end      <= 1'b0;
        end else begin
            game_tick    <= tick_d;
            world_reset  <= (cur_state == S_IDLE);
            fire_pending <= pending_d;
            sfx_shot     <= tick_d && pending_d;
            sfx_end      <= state_change && ((nxt_state == S_WIN) || (nxt_state == S_LOSE));
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized plus scripted bench for game_sequencer, checked cycle by cycle against
// a cycle-count reference model built from input history arrays.
module tb_game_sequencer;

    localparam int unsigned TDIV = 8;
    localparam int unsigned HOLD = 4;

    logic       board_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       fire_btn = 1'b0;
    logic       aliens_defeated = 1'b0;
    logic       reached_bottom = 1'b0;
    logic       bullet_onscreen = 1'b0;
    logic       game_tick, world_reset, fire_req, sfx_shot, sfx_end;
    logic [1:0] state;

    game_sequencer #(
        .TICK_DIV(TDIV),
        .END_HOLD_TICKS(HOLD),
        .CNT_W(3)
    ) dut (
        .board_clk(board_clk),
        .reset(reset),
        .start(start),
        .fire_btn(fire_btn),
        .aliens_defeated(aliens_defeated),
        .reached_bottom(reached_bottom),
        .bullet_onscreen(bullet_onscreen),
        .game_tick(game_tick),
        .world_reset(world_reset),
        .fire_req(fire_req),
        .sfx_shot(sfx_shot),
        .sfx_end(sfx_end),
        .state(state)
    );

    always #5 board_clk = ~board_clk;

    int checks = 0;
    int errors = 0;

    // Model: 0=IDLE 1=PLAY 2=WIN 3=LOSE; values describe the upcoming cycle
    int m_state = 0;
    int since   = 0;
    int held    = 0;
    bit m_pend = 0, m_tick = 0, m_wr = 1, m_shot = 0, m_end = 0;
    bit sh[4];
    bit fh[4];
    bit armed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit s, input bit f, input bit ad, input bit rb,
                              input bit bo, input bit rs);
        bit s_sync, s_rise, f_rise, tc, play_stays, new_pend, new_tick;
        int nxt;
        for (int i = 3; i > 0; i--) begin
            sh[i] = sh[i-1];
            fh[i] = fh[i-1];
        end
        sh[0] = s;
        fh[0] = f;
        if (rs) begin
            m_state = 0; since = 0; held = 0;
            m_pend = 0; m_tick = 0; m_wr = 1; m_shot = 0; m_end = 0;
            for (int i = 0; i < 3; i++) begin
                sh[i] = 0;
                fh[i] = 0;
            end
            return;
        end
        // Synchronized value seen this cycle is the raw input from two cycles back
        s_sync = sh[2];
        s_rise = sh[2] && !sh[3];
        f_rise = fh[2] && !fh[3];
        tc = (m_state != 0) && ((since % TDIV) == TDIV - 1);
        nxt = m_state;
        case (m_state)
            0: if (s_rise) nxt = 1;
            1: if (!s_sync) nxt = 0; else if (rb) nxt = 3; else if (ad) nxt = 2;
            default: if (held == HOLD && !s_sync) nxt = 0;
        endcase
        play_stays = (m_state == 1) && (nxt == 1);
        new_pend = play_stays && (m_pend ? !m_tick : (f_rise && !bo));
        new_tick = tc && play_stays;
        m_shot = new_tick && new_pend;
        m_end  = (nxt != m_state) && (nxt >= 2);
        m_wr   = (m_state == 0);
        if (nxt != m_state) begin
            since = 0;
            held  = 0;
        end else begin
            since++;
            if (tc && held < HOLD) held++;
        end
        m_state = nxt;
        m_tick  = new_tick;
        m_pend  = new_pend;
    endtask

    task automatic run(input bit s, input bit f, input bit ad, input bit rb,
                       input bit bo, input bit rs);
        @(negedge board_clk);
        if (armed) begin
            check_eq("state", state, m_state);
            check_eq("game_tick", game_tick, m_tick);
            check_eq("world_reset", world_reset, m_wr);
            check_eq("fire_req", fire_req, m_pend);
            check_eq("sfx_shot", sfx_shot, m_shot);
            check_eq("sfx_end", sfx_end, m_end);
        end
        start = s; fire_btn = f; aliens_defeated = ad;
        reached_bottom = rb; bullet_onscreen = bo; reset = rs;
        model_step(s, f, ad, rb, bo, rs);
        armed = 1;
    endtask

    bit r_s, r_f, r_bo;

    initial begin
        for (int i = 0; i < 4; i++) begin
            sh[i] = 0;
            fh[i] = 0;
        end
        repeat (3) run(0, 0, 0, 0, 0, 1);
        repeat (5) run(0, 0, 0, 0, 0, 0);
        // Start game, let several ticks go by
        repeat (70) run(1, 0, 0, 0, 0, 0);
        // Long fire press: exactly one request
        repeat (20) run(1, 1, 0, 0, 0, 0);
        repeat (20) run(1, 0, 0, 0, 0, 0);
        // Fire while a bullet is on screen: ignored
        repeat (10) run(1, 1, 0, 0, 1, 0);
        repeat (10) run(1, 0, 0, 0, 1, 0);
        // Both end flags at once: LOSE takes priority
        run(1, 0, 1, 1, 0, 0);
        repeat (40) run(1, 0, 0, 0, 0, 0);
        repeat (40) run(0, 0, 0, 0, 0, 0);
        // WIN entered with start already falling
        repeat (15) run(1, 0, 0, 0, 0, 0);
        run(0, 0, 1, 0, 0, 0);
        repeat (50) run(0, 0, 0, 0, 0, 0);
        // Reset while a fire request is pending
        repeat (12) run(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 30 && !m_pend; i++) run(1, 1, 0, 0, 0, 0);
        check_eq("pending_reached", m_pend, 1'b1);
        run(1, 1, 0, 0, 0, 1);
        repeat (5) run(1, 0, 0, 0, 0, 0);
        repeat (10) run(0, 0, 0, 0, 0, 0);
        // Randomized episodes
        r_s = 0; r_f = 0; r_bo = 0;
        for (int ep = 0; ep < 40; ep++) begin
            int len;
            len = $urandom_range(50, 150);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 59) == 0) r_s = !r_s;
                if ($urandom_range(0, 5) == 0)  r_f = !r_f;
                if ($urandom_range(0, 9) == 0)  r_bo = !r_bo;
                run(r_s, r_f, ($urandom_range(0, 59) == 0), ($urandom_range(0, 79) == 0),
                    r_bo, ($urandom_range(0, 399) == 0));
            end
        end
        run(0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
